mem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the simulation memory's port 0. It accepts a byte stream from the testbench or host link over a valid/ready handshake, packs each four bytes into a big-endian word, and writes the words to consecutive memory addresses from a fixed base. It holds the core in reset until the image is written, so the core only ever fetches a complete program.

---
 rtl/mem_loader_pkg.sv | 18 +
 rtl/mem_loader_byte_packer.sv | 63 ++++++
 rtl/mem_loader.sv | 131 +++++++++++++
 tb/tb_mem_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg
//   Shared definitions for the boot-time program loader: FSM state encoding,
//   bytes-per-word constant and the default memory geometry.
package mem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_DONE    = 3'd3,
      ST_ERR     = 3'd4
   } state_e;

   localparam int          WORD_BYTES    = 4;
   localparam logic [31:0] DEF_MEM_SIZE  = 32'd128;
   localparam logic [31:0] DEF_BASE_ADDR = 32'd64;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// byte_packer
//   Packs a stream of bytes into a big-endian 32-bit word. The first byte of
//   a word lands in [31:24], the fourth in [7:0].
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      discard any partial word and restart at byte 0
//   in_valid   a byte is accepted this cycle
//   in_data    the byte being accepted
//   byte_idx   index (0..3) of the next byte slot to be filled
//   word       packing register
//   word_full  set once byte 3 has been accepted, cleared by clear/rst
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic [1:0]  byte_idx,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] word_q, word_d;
   logic        word_full_q, word_full_d;

   always_comb begin
      byte_idx_d  = byte_idx_q;
      word_d      = word_q;
      word_full_d = word_full_q;
      if (clear) begin
         byte_idx_d  = 2'd0;
         word_d      = 32'd0;
         word_full_d = 1'b0;
      end else if (in_valid) begin
         // Byte k goes to bits [31-8k -: 8].
         for (int k = 0; k < 4; k++) begin
            if (byte_idx_q == 2'(k)) begin
               word_d[31-8*k -: 8] = in_data;
            end
         end
         byte_idx_d  = byte_idx_q + 2'd1;
         word_full_d = (byte_idx_q == 2'd3);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx_q  <= 2'd0;
         word_q      <= 32'd0;
         word_full_q <= 1'b0;
      end else begin
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         word_full_q <= word_full_d;
      end
   end

   assign byte_idx  = byte_idx_q;
   assign word      = word_q;
   assign word_full = word_full_q;

endmodule

// File: rtl/mem_loader.sv
// mem_loader
//   Boot-time program loader. Accepts bytes over a valid/ready handshake,
//   packs four at a time into big-endian words and writes them to
//   consecutive addresses from BASE_ADDR. The core is held in reset until
//   the whole image has been written.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   start, len_words        begin a load of len_words 32-bit words
//   byte_valid, byte_data   incoming byte stream
//   byte_ready              loader accepts a byte this cycle
//   mem_wr_en/mask/addr/wdata  write port to memory port 0
//   busy, done, err         load status
//   core_rst                reset to the core, released only in DONE
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter logic [31:0] MEM_SIZE  = DEF_MEM_SIZE,
   parameter int          LEN_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             mem_wr_en,
   output logic [3:0]       mem_wr_mask,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             core_rst
);

   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
   logic [LEN_W-1:0] len_q, len_d;

   logic             accept;
   logic             pk_clear;
   logic [1:0]       pk_idx;
   logic [31:0]      pk_word;
   logic             pk_full;
   logic [31:0]      end_addr;
   logic [LEN_W-1:0] cnt_inc;

   assign accept   = byte_valid && (state_q == ST_COLLECT);
   // The packer only holds data while collecting or writing a word; leaving
   // WRITE clears it so the next word starts at byte 0.
   assign pk_clear = (state_q != ST_COLLECT);
   assign end_addr = BASE_ADDR + 32'(len_words) * 32'(WORD_BYTES);
   assign cnt_inc  = word_cnt_q + CNT_ONE;

   byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (pk_clear),
      .in_valid  (accept),
      .in_data   (byte_data),
      .byte_idx  (pk_idx),
      .word      (pk_word),
      .word_full (pk_full)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               if (end_addr > MEM_SIZE) begin
                  state_d = ST_ERR;
               end else if (len_words == '0) begin
                  state_d = ST_DONE;
               end else begin
                  len_d      = len_words;
                  addr_d     = BASE_ADDR;
                  word_cnt_d = '0;
                  state_d    = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (accept && (pk_idx == 2'd3)) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            addr_d     = addr_q + 32'(WORD_BYTES);
            word_cnt_d = cnt_inc;
            state_d    = (cnt_inc == len_q) ? ST_DONE : ST_COLLECT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= 32'd0;
         word_cnt_q <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
      end
   end

   // Output decode from registered state only; rst additionally blocks a
   // write that would coincide with reset.
   assign byte_ready  = (state_q == ST_COLLECT);
   assign mem_wr_en   = (state_q == ST_WRITE) && pk_full && !rst;
   assign mem_wr_mask = mem_wr_en ? 4'hF : 4'h0;
   assign mem_addr    = (state_q == ST_WRITE) ? addr_q : 32'd0;
   assign mem_wdata   = (state_q == ST_WRITE) ? pk_word : 32'd0;
   assign busy        = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
   assign done        = (state_q == ST_DONE);
   assign err         = (state_q == ST_ERR);
   assign core_rst    = (state_q != ST_DONE);

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  len_words = 8'd0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic        mem_wr_en;
   logic [3:0]  mem_wr_mask;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic        core_rst;

   int tests = 0;
   int fails = 0;

   // Write log, filled at every rising edge where a write is presented.
   int          wr_total = 0;
   logic [31:0] wr_addr_log [0:63];
   logic [31:0] wr_data_log [0:63];

   always #5 clk = ~clk;

   mem_loader dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .len_words   (len_words),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_ready  (byte_ready),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_mask (mem_wr_mask),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .core_rst    (core_rst)
   );

   always @(posedge clk) begin
      if (mem_wr_en === 1'b1 && wr_total < 64) begin
         wr_addr_log[wr_total] <= mem_addr;
         wr_data_log[wr_total] <= mem_wdata;
         wr_total <= wr_total + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] len);
      start     = 1'b1;
      len_words = len;
      step();
      start     = 1'b0;
   endtask

   // Present one byte and hold it until accepted (bounded).
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_data  = b;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         tests++;
         fails++;
         $display("FAIL send_byte_timeout byte=%02h waited=%0d required<20", b, n);
      end
      step();
      byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      tests++;
      if ({byte_ready, mem_wr_en, mem_wr_mask, busy, done, err, core_rst} !== 10'b0_0_0000_0_0_0_1) begin
         fails++;
         $display("FAIL reset_ctrl got rdy=%b wr=%b mask=%h busy=%b done=%b err=%b crst=%b required 0 0 0 0 0 0 1",
                  byte_ready, mem_wr_en, mem_wr_mask, busy, done, err, core_rst);
      end
      tests++;
      if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         fails++;
         $display("FAIL reset_bus got addr=%h data=%h required 0 0", mem_addr, mem_wdata);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_two_word();
      logic [7:0] img [0:7];
      int base;
      img = '{8'h13, 8'h01, 8'h01, 8'hFE, 8'h23, 8'h2E, 8'h81, 8'h00};
      base = wr_total;
      do_start(8'd2);
      tests++;
      if (byte_ready !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL two_word_ready_latency got rdy=%b busy=%b required 1 1", byte_ready, busy);
      end
      for (int i = 0; i < 8; i++) send_byte(img[i]);
      // Now in the second WRITE cycle.
      tests++;
      if (mem_wr_en !== 1'b1 || mem_wr_mask !== 4'hF || mem_addr !== 32'd68 ||
          mem_wdata !== 32'h232E8100 || done !== 1'b0 || byte_ready !== 1'b0) begin
         fails++;
         $display("FAIL two_word_write_cycle got wr=%b mask=%h addr=%0d data=%h done=%b rdy=%b required 1 f 68 232e8100 0 0",
                  mem_wr_en, mem_wr_mask, mem_addr, mem_wdata, done, byte_ready);
      end
      step();
      tests++;
      if (done !== 1'b1 || core_rst !== 1'b0 || busy !== 1'b0 || mem_wr_en !== 1'b0) begin
         fails++;
         $display("FAIL two_word_done got done=%b crst=%b busy=%b wr=%b required 1 0 0 0", done, core_rst, busy, mem_wr_en);
      end
      tests++;
      if (wr_total - base !== 2) begin
         fails++;
         $display("FAIL two_word_count got %0d required 2", wr_total - base);
      end else begin
         tests++;
         if (wr_addr_log[base] !== 32'd64 || wr_data_log[base] !== 32'h130101FE ||
             wr_addr_log[base+1] !== 32'd68 || wr_data_log[base+1] !== 32'h232E8100) begin
            fails++;
            $display("FAIL two_word_data got %0d:%h %0d:%h required 64:130101fe 68:232e8100",
                     wr_addr_log[base], wr_data_log[base], wr_addr_log[base+1], wr_data_log[base+1]);
         end
      end
   endtask

   task automatic test_gapped();
      logic [7:0] img [0:7];
      int base;
      int gap_bad;
      img = '{8'h13, 8'h01, 8'h01, 8'hFE, 8'h23, 8'h2E, 8'h81, 8'h00};
      base = wr_total;
      gap_bad = 0;
      do_start(8'd2);
      for (int i = 0; i < 8; i++) begin
         byte_valid = 1'b0;
         step();
         // Gaps other than the one overlapping a WRITE cycle keep ready high.
         if (i % 4 != 0 && byte_ready !== 1'b1) gap_bad++;
         send_byte(img[i]);
      end
      step();
      tests++;
      if (gap_bad != 0) begin
         fails++;
         $display("FAIL gapped_ready got %0d low gaps required 0", gap_bad);
      end
      tests++;
      if (done !== 1'b1 || wr_total - base !== 2) begin
         fails++;
         $display("FAIL gapped_count got done=%b writes=%0d required 1 2", done, wr_total - base);
      end else begin
         tests++;
         if (wr_addr_log[base] !== 32'd64 || wr_data_log[base] !== 32'h130101FE ||
             wr_addr_log[base+1] !== 32'd68 || wr_data_log[base+1] !== 32'h232E8100) begin
            fails++;
            $display("FAIL gapped_data got %0d:%h %0d:%h required 64:130101fe 68:232e8100",
                     wr_addr_log[base], wr_data_log[base], wr_addr_log[base+1], wr_data_log[base+1]);
         end
      end
   endtask

   task automatic test_zero_len();
      int base;
      rst = 1'b1;
      step();
      rst = 1'b0;
      base = wr_total;
      do_start(8'd0);
      tests++;
      if (done !== 1'b1 || core_rst !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
         fails++;
         $display("FAIL zero_len_state got done=%b crst=%b busy=%b rdy=%b required 1 0 0 0", done, core_rst, busy, byte_ready);
      end
      step();
      step();
      tests++;
      if (wr_total - base !== 0) begin
         fails++;
         $display("FAIL zero_len_writes got %0d required 0", wr_total - base);
      end
   endtask

   task automatic test_overflow();
      int base;
      int rdy_seen;
      base = wr_total;
      rdy_seen = 0;
      do_start(8'd17);
      tests++;
      if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL overflow_state got err=%b crst=%b done=%b busy=%b required 1 1 0 0", err, core_rst, done, busy);
      end
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      for (int i = 0; i < 6; i++) begin
         if (byte_ready === 1'b1) rdy_seen++;
         step();
      end
      byte_valid = 1'b0;
      tests++;
      if (rdy_seen != 0 || wr_total - base !== 0 || err !== 1'b1) begin
         fails++;
         $display("FAIL overflow_quiet got ready_cycles=%0d writes=%0d err=%b required 0 0 1", rdy_seen, wr_total - base, err);
      end
   endtask

   task automatic test_reset_mid_word();
      int base;
      base = wr_total;
      do_start(8'd1);
      send_byte(8'h01);
      send_byte(8'h02);
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (busy !== 1'b0 || byte_ready !== 1'b0 || err !== 1'b0 || done !== 1'b0 || core_rst !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_idle got busy=%b rdy=%b err=%b done=%b crst=%b required 0 0 0 0 1",
                  busy, byte_ready, err, done, core_rst);
      end
      do_start(8'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      step();
      tests++;
      if (done !== 1'b1 || wr_total - base !== 1) begin
         fails++;
         $display("FAIL rst_mid_count got done=%b writes=%0d required 1 1", done, wr_total - base);
      end else begin
         tests++;
         if (wr_addr_log[base] !== 32'd64 || wr_data_log[base] !== 32'hAABBCCDD) begin
            fails++;
            $display("FAIL rst_mid_data got %0d:%h required 64:aabbccdd", wr_addr_log[base], wr_data_log[base]);
         end
      end
   endtask

   task automatic test_start_handling();
      logic [7:0] img [0:7];
      int base;
      img = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
      base = wr_total;
      do_start(8'd2);
      send_byte(img[0]);
      send_byte(img[1]);
      do_start(8'd1);   // ignored while collecting
      for (int i = 2; i < 8; i++) send_byte(img[i]);
      step();
      tests++;
      if (done !== 1'b1 || wr_total - base !== 2) begin
         fails++;
         $display("FAIL start_ignored_count got done=%b writes=%0d required 1 2", done, wr_total - base);
      end else begin
         tests++;
         if (wr_data_log[base] !== 32'h10203040 || wr_addr_log[base+1] !== 32'd68 ||
             wr_data_log[base+1] !== 32'h50607080) begin
            fails++;
            $display("FAIL start_ignored_data got %h %0d:%h required 10203040 68:50607080",
                     wr_data_log[base], wr_addr_log[base+1], wr_data_log[base+1]);
         end
      end
      base = wr_total;
      do_start(8'd1);
      tests++;
      if (done !== 1'b0 || core_rst !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL reload_state got done=%b crst=%b busy=%b required 0 1 1", done, core_rst, busy);
      end
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      step();
      tests++;
      if (done !== 1'b1 || wr_total - base !== 1) begin
         fails++;
         $display("FAIL reload_count got done=%b writes=%0d required 1 1", done, wr_total - base);
      end else begin
         tests++;
         if (wr_addr_log[base] !== 32'd64 || wr_data_log[base] !== 32'h11223344) begin
            fails++;
            $display("FAIL reload_data got %0d:%h required 64:11223344", wr_addr_log[base], wr_data_log[base]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_gapped();
      test_zero_len();
      test_overflow();
      test_reset_mid_word();
      test_start_handling();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
